// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: PIN-entry gating, failed-attempt lockout,
// idle timeouts and withdrawal hand-off to the cash dispenser.
module atm_session_ctrl #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned ENTRY_CYCLES   = 32,
  parameter int unsigned IDLE_CYCLES    = 32,
  parameter int unsigned LOCKOUT_CYCLES = 64,
  parameter int unsigned AMT_W          = 8,
  parameter int unsigned INIT_BAL       = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic             lock_unlock,
  input  logic             attempt_done,
  input  logic             eject_req,
  input  logic             wd_req,
  input  logic [AMT_W-1:0] wd_amt,
  input  logic             disp_ready,
  output logic             lock_clr,
  output logic             lock_en,
  output logic             session_active,
  output logic             disp_valid,
  output logic [AMT_W-1:0] disp_amt,
  output logic             deny,
  output logic             card_eject,
  output logic             card_retain,
  output logic             locked_out,
  output logic [AMT_W-1:0] balance,
  output logic [1:0]       fail_cnt
);

  // One timer is shared by ENTRY, AUTH and LOCKOUT; size it for the longest.
  localparam int unsigned MAX_CYC_A = (ENTRY_CYCLES > IDLE_CYCLES) ? ENTRY_CYCLES : IDLE_CYCLES;
  localparam int unsigned MAX_CYC   = (MAX_CYC_A > LOCKOUT_CYCLES) ? MAX_CYC_A : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W     = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ENTRY,
    S_AUTH,
    S_DISPENSE,
    S_EJECT,
    S_LOCKOUT
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       fail_inc;
  logic             amt_bad;

  // Failure count after this attempt, one bit wider so MAX_TRIES=3 compares cleanly.
  assign fail_inc = {1'b0, fail_cnt} + 3'd1;
  assign amt_bad  = (wd_amt == '0) || (wd_amt > balance);

  // Level outputs decoded straight from the state register.
  assign lock_clr       = (state == S_CLEAR);
  assign lock_en        = (state == S_ENTRY);
  assign session_active = (state == S_AUTH) || (state == S_DISPENSE);
  assign disp_valid     = (state == S_DISPENSE);
  assign card_eject     = (state == S_EJECT);
  assign locked_out     = (state == S_LOCKOUT);

  // Session FSM with timer, attempt counter, balance and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tmr         <= '0;
      fail_cnt    <= '0;
      balance     <= AMT_W'(INIT_BAL);
      disp_amt    <= '0;
      deny        <= 1'b0;
      card_retain <= 1'b0;
    end else begin
      deny        <= 1'b0;
      card_retain <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (card_in) state <= S_CLEAR;
        end
        S_CLEAR: begin
          tmr   <= '0;
          state <= S_ENTRY;
        end
        S_ENTRY: begin
          tmr <= tmr + TMR_W'(1);
          if (!card_in) begin
            state <= S_IDLE;
          end else if (lock_unlock) begin
            fail_cnt <= '0;
            tmr      <= '0;
            state    <= S_AUTH;
          end else if (attempt_done || (tmr == TMR_W'(ENTRY_CYCLES - 1))) begin
            fail_cnt <= fail_inc[1:0];
            if (fail_inc == 3'(MAX_TRIES)) begin
              tmr         <= '0;
              card_retain <= 1'b1;
              state       <= S_LOCKOUT;
            end else begin
              state <= S_CLEAR;
            end
          end
        end
        S_AUTH: begin
          // Saturate so a denied request on the last idle cycle still times out next cycle.
          if (tmr < TMR_W'(IDLE_CYCLES - 1)) tmr <= tmr + TMR_W'(1);
          if (!card_in) begin
            state <= S_IDLE;
          end else if (eject_req) begin
            state <= S_EJECT;
          end else if (wd_req) begin
            if (amt_bad) begin
              deny <= 1'b1;
            end else begin
              disp_amt <= wd_amt;
              tmr      <= '0;
              state    <= S_DISPENSE;
            end
          end else if (tmr >= TMR_W'(IDLE_CYCLES - 1)) begin
            state <= S_EJECT;
          end
        end
        S_DISPENSE: begin
          if (disp_ready) begin
            balance <= balance - disp_amt;
            tmr     <= '0;
            state   <= S_AUTH;
          end
        end
        S_EJECT: begin
          if (!card_in) begin
            fail_cnt <= '0;
            state    <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          if (tmr == TMR_W'(LOCKOUT_CYCLES - 1)) begin
            fail_cnt <= '0;
            tmr      <= '0;
            state    <= S_IDLE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: session-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_atm_session_ctrl;

  localparam int unsigned AMT_W          = 8;
  localparam int unsigned MAX_TRIES      = 3;
  localparam int unsigned ENTRY_CYCLES   = 32;
  localparam int unsigned IDLE_CYCLES    = 32;
  localparam int unsigned LOCKOUT_CYCLES = 64;
  localparam int unsigned INIT_BAL       = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             card_in = 1'b0;
  logic             lock_unlock = 1'b0;
  logic             attempt_done = 1'b0;
  logic             eject_req = 1'b0;
  logic             wd_req = 1'b0;
  logic [AMT_W-1:0] wd_amt = '0;
  logic             disp_ready = 1'b0;
  logic             lock_clr, lock_en, session_active, disp_valid, deny;
  logic             card_eject, card_retain, locked_out;
  logic [AMT_W-1:0] disp_amt, balance;
  logic [1:0]       fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .MAX_TRIES(MAX_TRIES), .ENTRY_CYCLES(ENTRY_CYCLES), .IDLE_CYCLES(IDLE_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .AMT_W(AMT_W), .INIT_BAL(INIT_BAL)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .lock_unlock(lock_unlock),
    .attempt_done(attempt_done), .eject_req(eject_req), .wd_req(wd_req),
    .wd_amt(wd_amt), .disp_ready(disp_ready), .lock_clr(lock_clr), .lock_en(lock_en),
    .session_active(session_active), .disp_valid(disp_valid), .disp_amt(disp_amt),
    .deny(deny), .card_eject(card_eject), .card_retain(card_retain),
    .locked_out(locked_out), .balance(balance), .fail_cnt(fail_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Session model: which phase the customer is in and how long they have been there.
  localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_ENTRY = 2, PH_AUTH = 3,
                 PH_DISP = 4, PH_EJECT = 5, PH_LOCK = 6;
  int ph = PH_IDLE;
  int age = 0;
  int m_fail = 0;
  int m_bal = INIT_BAL;
  int m_amt = 0;
  bit m_deny = 1'b0;
  bit m_retain = 1'b0;

  always @(posedge clk) begin
    int nxt;
    nxt = ph;
    m_deny = 1'b0;
    m_retain = 1'b0;
    if (rst) begin
      nxt = PH_IDLE; m_fail = 0; m_bal = INIT_BAL; m_amt = 0; ph = -1;
    end else begin
      case (ph)
        PH_IDLE:  if (card_in) nxt = PH_CLEAR;
        PH_CLEAR: nxt = PH_ENTRY;
        PH_ENTRY: begin
          if (!card_in) nxt = PH_IDLE;
          else if (lock_unlock) begin m_fail = 0; nxt = PH_AUTH; end
          else if (attempt_done || age + 1 >= ENTRY_CYCLES) begin
            m_fail = m_fail + 1;
            if (m_fail >= MAX_TRIES) begin nxt = PH_LOCK; m_retain = 1'b1; end
            else nxt = PH_CLEAR;
          end
        end
        PH_AUTH: begin
          if (!card_in) nxt = PH_IDLE;
          else if (eject_req) nxt = PH_EJECT;
          else if (wd_req && (wd_amt == 0 || int'(wd_amt) > m_bal)) m_deny = 1'b1;
          else if (wd_req) begin m_amt = int'(wd_amt); nxt = PH_DISP; end
          else if (age + 1 >= IDLE_CYCLES) nxt = PH_EJECT;
        end
        PH_DISP: if (disp_ready) begin m_bal = m_bal - m_amt; nxt = PH_DISP + 100; end
        PH_EJECT: if (!card_in) begin m_fail = 0; nxt = PH_IDLE; end
        PH_LOCK: if (age + 1 >= LOCKOUT_CYCLES) begin m_fail = 0; nxt = PH_IDLE; end
        default: nxt = PH_IDLE;
      endcase
    end
    // Returning from a dispense re-enters AUTH with a fresh idle window.
    if (nxt == PH_DISP + 100) begin ph = PH_AUTH; age = 0; end
    else if (nxt != ph) begin ph = nxt; age = 0; end
    else age = age + 1;
  end

  // Every cycle, all outputs must match the model.
  always @(posedge clk) begin
    #1;
    check("lock_clr", lock_clr, ph == PH_CLEAR);
    check("lock_en", lock_en, ph == PH_ENTRY);
    check("session_active", session_active, ph == PH_AUTH || ph == PH_DISP);
    check("disp_valid", disp_valid, ph == PH_DISP);
    check("disp_amt", disp_amt, m_amt);
    check("deny", deny, m_deny);
    check("card_eject", card_eject, ph == PH_EJECT);
    check("card_retain", card_retain, m_retain);
    check("locked_out", locked_out, ph == PH_LOCK);
    check("balance", balance, m_bal);
    check("fail_cnt", fail_cnt, m_fail);
  end

  task automatic wait_lock_en();
    int k = 0;
    while (!lock_en && k < 50) begin @(negedge clk); k++; end
    check("wait_lock_en", lock_en, 1);
  endtask

  task automatic pulse_attempt();
    attempt_done = 1'b1;
    @(negedge clk);
    attempt_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check("rst_balance", balance, 100);
    check("rst_fail", fail_cnt, 0);
    check("rst_valid", disp_valid, 0);
    check("rst_amt", disp_amt, 0);
    rst = 1'b0;

    // Card in, unlock, rejected requests, then a good withdrawal of 40.
    card_in = 1'b1;
    @(negedge clk); check("clr_pulse", lock_clr, 1);
    @(negedge clk); check("clr_once", lock_clr, 0); check("entry_en", lock_en, 1);
    lock_unlock = 1'b1;
    @(negedge clk); lock_unlock = 1'b0; check("auth_active", session_active, 1);
    wd_req = 1'b1; wd_amt = 8'd120;
    @(negedge clk); check("deny_big", deny, 1); wd_amt = 8'd0;
    @(negedge clk); check("deny_zero", deny, 1); wd_req = 1'b0;
    @(negedge clk); check("deny_gone", deny, 0); check("bal_kept", balance, 100);
    check("no_valid", disp_valid, 0);
    wd_req = 1'b1; wd_amt = 8'd40;
    @(negedge clk); wd_req = 1'b0; check("valid", disp_valid, 1); check("amt40", disp_amt, 40);
    repeat (3) @(negedge clk);
    check("amt_held", disp_amt, 40); check("valid_held", disp_valid, 1);
    disp_ready = 1'b1;
    @(negedge clk); disp_ready = 1'b0;
    check("bal60", balance, 60); check("still_auth", session_active, 1); check("valid_drop", disp_valid, 0);

    // Idle timeout: 32 quiet cycles in AUTH, then eject held until card removed.
    k = 0;
    while (!card_eject && k < 100) begin @(negedge clk); k++; end
    check("idle_cycles", k, 32);
    repeat (3) @(negedge clk);
    check("eject_hold", card_eject, 1);
    card_in = 1'b0;
    @(negedge clk); check("eject_done", card_eject, 0); check("idle_inactive", session_active, 0);

    // Lockout after three failed attempts; card toggling ignored while locked.
    card_in = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_lock_en();
      pulse_attempt();
      if (t < 2) check("retry_clr", lock_clr, 1);
    end
    check("retain", card_retain, 1); check("locked", locked_out, 1); check("fail3", fail_cnt, 3);
    k = 0;
    while (locked_out && k < 200) begin card_in = ~card_in; @(negedge clk); k++; end
    card_in = 1'b0;
    check("lock_cycles", k, 64);
    check("lock_fail_clr", fail_cnt, 0);
    @(negedge clk); check("lock_idle", lock_clr, 0);

    // Persistent count: timeout failure, pulse failure, removal, reinsertion, failure.
    card_in = 1'b1;
    wait_lock_en();
    k = 0;
    while (!lock_clr && k < 100) begin @(negedge clk); k++; end
    check("entry_timeout", k, 32); check("fail1", fail_cnt, 1);
    wait_lock_en();
    pulse_attempt();
    check("fail2", fail_cnt, 2);
    wait_lock_en();
    card_in = 1'b0;
    @(negedge clk); check("removed_en", lock_en, 0); check("removed_fail", fail_cnt, 2);
    card_in = 1'b1;
    wait_lock_en();
    pulse_attempt();
    check("persist_lock", locked_out, 1); check("persist_fail", fail_cnt, 3);
    k = 0;
    while (locked_out && k < 200) begin @(negedge clk); k++; end
    check("persist_unlock", locked_out, 0);

    // Reset in the middle of a dispense.
    wait_lock_en();
    lock_unlock = 1'b1;
    @(negedge clk); lock_unlock = 1'b0;
    wd_req = 1'b1; wd_amt = 8'd30;
    @(negedge clk); wd_req = 1'b0; check("rd_valid", disp_valid, 1); check("rd_amt", disp_amt, 30);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; card_in = 1'b0;
    check("rd_valid0", disp_valid, 0); check("rd_bal", balance, 100);
    check("rd_fail", fail_cnt, 0); check("rd_active", session_active, 0); check("rd_amt0", disp_amt, 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Session sequencer for the ATM front end. Owns the PIN-sequence lock FSM: clears it, gates entry into it, and counts failed attempts.
- Runs an authenticated withdrawal session against an internal balance register and enforces card-retain lockout and idle timeouts.
- Hands approved withdrawals to the cash dispenser over a valid/ready handshake.

Parameters:
- MAX_TRIES, 3: failed PIN attempts that trigger lockout (≥1).
- ENTRY_CYCLES, 32: maximum cycles spent in ENTRY per attempt before the attempt counts as failed.
- IDLE_CYCLES, 32: maximum cycles in AUTH without a request before the card is ejected.
- LOCKOUT_CYCLES, 64: cycles spent in LOCKOUT.
- AMT_W, 8: width of amounts and balance.
- INIT_BAL, 100: balance value loaded at reset.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- card_in, in, 1: card-present level.
- lock_unlock, in, 1: unlock output of the lock FSM.
- attempt_done, in, 1: one-cycle pulse; user pressed enter.
- eject_req, in, 1: one-cycle pulse; user ends the session.
- wd_req, in, 1: one-cycle pulse; withdrawal request.
- wd_amt, in, AMT_W: requested amount, sampled with wd_req.
- disp_ready, in, 1: dispenser accepts.
- lock_clr, out, 1: one-cycle clear pulse to the lock FSM.
- lock_en, out, 1: enables X/Y entry into the lock FSM.
- session_active, out, 1: high in AUTH and DISPENSE.
- disp_valid, out, 1: dispense request.
- disp_amt, out, AMT_W: amount to dispense.
- deny, out, 1: one-cycle pulse; request rejected.
- card_eject, out, 1: eject mechanism drive.
- card_retain, out, 1: one-cycle pulse; card swallowed.
- locked_out, out, 1: high in LOCKOUT.
- balance, out, AMT_W: current balance.
- fail_cnt, out, 2: current failed-attempt count.

Behaviour:
- All outputs are registered or decoded from the state register. A condition sampled at edge N takes effect at N+1.
- Reset (sync, highest priority at any time, including mid-DISPENSE):
  - state = IDLE, fail_cnt = 0, balance = INIT_BAL, all timers = 0.
  - All outputs 0 except balance = INIT_BAL; disp_amt = 0.
- States: IDLE, CLEAR, ENTRY, AUTH, DISPENSE, EJECT, LOCKOUT.
- IDLE: card_in = 1 → CLEAR.
- CLEAR: lock_clr = 1 for exactly one cycle; ENTRY timer zeroed → ENTRY.
- ENTRY: lock_en = 1; timer increments. Priority, high to low:
  - card_in = 0 → IDLE; fail_cnt unchanged.
  - lock_unlock = 1 → AUTH; fail_cnt = 0.
  - attempt_done = 1, or timer == ENTRY_CYCLES-1 → failure: fail_cnt+1.
    - If the new fail_cnt == MAX_TRIES → LOCKOUT; card_retain pulses one cycle.
    - Otherwise → CLEAR.
- AUTH: idle timer increments and resets on any accepted wd_req. Priority, high to low:
  - card_in = 0 → IDLE.
  - eject_req → EJECT.
  - wd_req:
    - wd_amt == 0 or wd_amt > balance → deny pulse next cycle; stay in AUTH; balance unchanged.
    - Otherwise latch disp_amt = wd_amt → DISPENSE.
  - timer == IDLE_CYCLES-1 → EJECT.
- DISPENSE:
  - disp_valid = 1; disp_amt held stable until the handshake.
  - On disp_valid & disp_ready: balance = balance - disp_amt (never underflows, guaranteed by the check); → AUTH; idle timer = 0.
  - card_in, eject_req and wd_req are ignored until the handshake completes.
- EJECT: card_eject = 1 while card_in = 1. card_in = 0 → IDLE with fail_cnt = 0.
- LOCKOUT:
  - locked_out = 1; lock_en = 0; card_in and all requests are ignored.
  - After LOCKOUT_CYCLES cycles → IDLE; fail_cnt = 0.
- Persistence: fail_cnt survives card removal in ENTRY. It clears only on unlock, eject completion, lockout expiry, or rst.
- The balance register persists across sessions and changes only on a dispense handshake or rst.

Test Plan:
1. Successful withdrawal: rst, then card_in = 1 → lock_clr pulses one cycle, lock_en = 1; lock_unlock = 1 → session_active = 1. wd_req with wd_amt = 40 → disp_valid = 1, disp_amt = 40. disp_ready after 3 cycles → balance = 60, session_active stays 1.
2. Lockout: three attempt_done pulses with lock_unlock = 0 → lock_clr after each of the first two failures. On the third: card_retain pulse, locked_out = 1 for 64 cycles; card_in toggling is ignored. Then IDLE with fail_cnt = 0.
3. Rejected requests: balance = 100, wd_amt = 120 → deny pulse; wd_amt = 0 → deny pulse. Balance stays 100, disp_valid stays 0.
4. Idle timeout: in AUTH with no requests for 32 cycles → card_eject = 1, held until card_in = 0, then IDLE.
5. Persistent fail count: two failures, card removed, card reinserted, one more failure → LOCKOUT entered (fail_cnt reached 3).
6. Reset mid-dispense: rst while disp_valid = 1 and disp_ready = 0 → next cycle disp_valid = 0, state IDLE, balance = 100, fail_cnt = 0.
